// File: rtl/wb_stage_pkg.sv
// Shared write-back types: register bus widths, load funct3 codes and the
// divider FIFO entry layout.
package wb_stage_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    reg_addr_t waddr;
    reg_bus_t  wdata;
  } div_entry_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data extraction: selects the byte/halfword addressed by addr_lo from the
// raw memory word and sign- or zero-extends it to a full register value.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  reg_bus_t   rdata,
  output reg_bus_t   word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  // Halfword misalignment is trapped upstream, so only addr_lo[1] matters.
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: every path assigns word (default arm included), so no latch is inferred.
  always_comb begin
    case (funct3)
      F3_LB:   word = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   word = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  word = {24'd0, byte_sel};
      F3_LHU:  word = {16'd0, half_sel};
      default: word = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: merges in-order MEM results with buffered divider results
// onto the single registered regfile write port, with starvation protection.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DIV_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_wreg,
  input  reg_addr_t       mem_waddr,
  input  reg_bus_t        mem_wdata,
  input  logic            mem_is_load,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_addr_lo,
  input  reg_bus_t        mem_rdata,
  input  logic            div_valid,
  output logic            div_ready,
  input  reg_addr_t       div_waddr,
  input  reg_bus_t        div_wdata,
  output logic            we,
  output reg_addr_t       waddr,
  output reg_bus_t        wdata
);

  localparam int PTR_W = (DIV_FIFO_DEPTH > 1) ? $clog2(DIV_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  div_entry_t       fifo_q [DIV_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic [CNT_W-1:0] starve_cnt;
  logic             force_drain;

  logic       empty, full;
  logic       mem_useful, enq, drain;
  div_entry_t head;
  reg_bus_t   load_word, mem_data;

  wb_stage_load_align u_load_align (
    .funct3  (mem_funct3),
    .addr_lo (mem_addr_lo),
    .rdata   (mem_rdata),
    .word    (load_word)
  );

  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DIV_FIFO_DEPTH));

  assign mem_ready = rst & ~force_drain;
  assign div_ready = rst & ~full;

  // A MEM slot that writes nothing (x0 or no wreg) is free for the FIFO head.
  assign mem_useful = mem_valid & mem_ready & mem_wreg & (mem_waddr != '0);
  assign enq        = div_valid & div_ready;
  assign drain      = ~empty & ~mem_useful;
  assign head       = fifo_q[rd_ptr];
  assign mem_data   = mem_is_load ? load_word : mem_wdata;

  // NOTE: FIFO storage has no reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr] <= '{waddr: div_waddr, wdata: div_wdata};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we          <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      force_drain <= 1'b0;
    end else begin
      if (mem_useful) begin
        we    <= 1'b1;
        waddr <= mem_waddr;
        wdata <= mem_data;
      end else if (drain) begin
        we    <= (head.waddr != '0);
        waddr <= head.waddr;
        wdata <= head.wdata;
      end else begin
        we <= 1'b0;
      end

      if (enq)   wr_ptr <= wr_ptr + 1'b1;
      if (drain) rd_ptr <= rd_ptr + 1'b1;

      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Reaching the limit forces exactly one MEM-blocked drain cycle.
      if (empty || drain) begin
        starve_cnt  <= '0;
        force_drain <= 1'b0;
      end else begin
        starve_cnt  <= starve_cnt + 1'b1;
        force_drain <= (starve_cnt == CNT_W'(STARVE_LIMIT - 1));
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic,
// checked by a scoreboard fed at handshake time and drained by a write monitor.
module tb_wb_stage;

  logic        clk, rst;
  logic        mem_valid, mem_ready, mem_wreg, mem_is_load;
  logic [4:0]  mem_waddr, div_waddr, waddr;
  logic [31:0] mem_wdata, mem_rdata, div_wdata, wdata;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic        div_valid, div_ready, we;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t  mem_q[$];
  wr_t  div_q[$];
  logic expect_mem = 1'b0;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wreg(mem_wreg),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
    .div_valid(div_valid), .div_ready(div_ready), .div_waddr(div_waddr),
    .div_wdata(div_wdata), .we(we), .waddr(waddr), .wdata(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference load semantics written directly from the funct3 table.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * lo)) & 32'h0000_00FF;
    h = (rd >> (16 * lo[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  // Scoreboard feed: capture accepted transactions at the edge they are taken.
  always @(posedge clk) begin
    if (!rst) begin
      mem_q.delete();
      div_q.delete();
      expect_mem = 1'b0;
    end else begin
      wr_t e;
      expect_mem = 1'b0;
      if (mem_valid && mem_ready && mem_wreg && mem_waddr != 5'd0) begin
        e.a = mem_waddr;
        e.d = mem_is_load ? load_model(mem_funct3, mem_addr_lo, mem_rdata) : mem_wdata;
        mem_q.push_back(e);
        expect_mem = 1'b1;
      end
      if (div_valid && div_ready) begin
        e.a = div_waddr;
        e.d = div_wdata;
        div_q.push_back(e);
      end
    end
  end

  // Write monitor: a useful MEM accept owns the next write; otherwise any write
  // must be the oldest pending divider result.
  always @(negedge clk) begin
    wr_t e;
    if (expect_mem) begin
      e = mem_q.pop_front();
      check("mem_we", {31'd0, we}, 32'd1);
      check("mem_waddr", {27'd0, waddr}, {27'd0, e.a});
      check("mem_wdata", wdata, e.d);
    end else if (we === 1'b1) begin
      while (div_q.size() > 0 && div_q[0].a == 5'd0) void'(div_q.pop_front());
      if (div_q.size() == 0) begin
        check("spurious_we", {27'd0, waddr}, 32'hFFFF_FFFF);
      end else begin
        e = div_q.pop_front();
        check("div_waddr", {27'd0, waddr}, {27'd0, e.a});
        check("div_wdata", wdata, e.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_valid = 1'b0;
    div_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_div(input logic [4:0] a, input logic [31:0] d);
    int t = 0;
    div_valid = 1'b1;
    div_waddr = a;
    div_wdata = d;
    do begin
      @(posedge clk);
      t++;
    end while (!div_ready && t < 50);
    if (t >= 50) check("div_accept_timeout", 32'd0, 32'd1);
    #1;
    div_valid = 1'b0;
  endtask

  // Useful non-load MEM results on x1..x15; divider traffic uses x16..x31,
  // which keeps the no-shared-destination precondition true by construction.
  task automatic mem_stream(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      mem_valid   = 1'b1;
      mem_wreg    = 1'b1;
      mem_is_load = 1'b0;
      mem_waddr   = 5'($urandom_range(1, 15));
      mem_wdata   = $urandom;
      do begin
        @(posedge clk);
        t++;
      end while (!mem_ready && t < 50);
      if (t >= 50) check("mem_accept_timeout", 32'd0, 32'd1);
      #1;
    end
    mem_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    mem_valid = 0; mem_wreg = 0; mem_waddr = 0; mem_wdata = 0; mem_is_load = 0;
    mem_funct3 = 0; mem_addr_lo = 0; mem_rdata = 0;
    div_valid = 0; div_waddr = 0; div_wdata = 0;

    // Reset held for three cycles
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_we", {31'd0, we}, 32'd0);
      check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
      check("rst_div_ready", {31'd0, div_ready}, 32'd0);
    end
    check("rst_waddr", {27'd0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rel_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("rel_div_ready", {31'd0, div_ready}, 32'd1);

    // LB at byte 3, then LHU at upper half of the same word
    mem_valid = 1; mem_wreg = 1; mem_waddr = 5; mem_is_load = 1;
    mem_funct3 = 3'b000; mem_addr_lo = 2'd3; mem_rdata = 32'h80FF_1234;
    step();
    mem_funct3 = 3'b101; mem_addr_lo = 2'd2; mem_waddr = 6;
    @(negedge clk);
    check("lb_we", {31'd0, we}, 32'd1);
    check("lb_waddr", {27'd0, waddr}, 32'd5);
    check("lb_wdata", wdata, 32'hFFFF_FF80);
    step();
    mem_valid = 0; mem_is_load = 0;
    @(negedge clk);
    check("lhu_waddr", {27'd0, waddr}, 32'd6);
    check("lhu_wdata", wdata, 32'h0000_80FF);
    idle(2);

    // Lone divider result: visible two cycles after enqueue
    div_valid = 1; div_waddr = 7; div_wdata = 32'h2A;
    step();
    div_valid = 0;
    @(negedge clk);
    check("div_lat_n1_we", {31'd0, we}, 32'd0);
    @(negedge clk);
    check("div_lat_n2_we", {31'd0, we}, 32'd1);
    check("div_lat_waddr", {27'd0, waddr}, 32'd7);
    check("div_lat_wdata", wdata, 32'h2A);
    idle(3);

    // Three back-to-back divider results against a full FIFO
    fork
      mem_stream(6);
      begin
        send_div(16, 32'hA000_0001);
        send_div(17, 32'hA000_0002);
        @(negedge clk);
        check("fifo_full_ready", {31'd0, div_ready}, 32'd0);
        send_div(18, 32'hA000_0003);
      end
    join
    idle(6);
    check("order_drained", div_q.size(), 32'd0);

    // Starvation: continuous useful MEM traffic with one queued result
    fork
      mem_stream(14);
      begin
        send_div(20, 32'hDEAD_0005);
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          check("starve_ready_hi", {31'd0, mem_ready}, 32'd1);
        end
        @(negedge clk);
        check("starve_ready_lo", {31'd0, mem_ready}, 32'd0);
        @(negedge clk);
        check("starve_resume", {31'd0, mem_ready}, 32'd1);
        check("starve_we", {31'd0, we}, 32'd1);
        check("starve_waddr", {27'd0, waddr}, 32'd20);
      end
    join
    idle(4);

    // x0 MEM write frees the slot for the FIFO head
    mem_valid = 1; mem_wreg = 1; mem_waddr = 3; mem_is_load = 0; mem_wdata = 32'h111;
    div_valid = 1; div_waddr = 21; div_wdata = 32'hABCD;
    step();
    mem_waddr = 0; div_valid = 0;
    step();
    mem_valid = 0;
    @(negedge clk);
    check("x0_slot_we", {31'd0, we}, 32'd1);
    check("x0_slot_waddr", {27'd0, waddr}, 32'd21);
    idle(3);

    // Reset with a full FIFO discards its contents
    mem_valid = 1; mem_wreg = 1; mem_waddr = 4; mem_wdata = 32'h222;
    div_valid = 1; div_waddr = 22; div_wdata = 32'h16;
    step();
    mem_waddr = 8; div_waddr = 23; div_wdata = 32'h17;
    step();
    rst = 0; mem_valid = 0; div_valid = 0;
    @(negedge clk);
    check("midrst_div_ready", {31'd0, div_ready}, 32'd0);
    step();
    step();
    rst = 1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_we", {31'd0, we}, 32'd0);
    end
    check("post_rst_div_ready", {31'd0, div_ready}, 32'd1);

    // Randomized mixed traffic
    for (int i = 0; i < 400; i++) begin
      mem_valid   = ($urandom_range(0, 3) != 0);
      mem_wreg    = ($urandom_range(0, 7) != 0);
      mem_waddr   = 5'($urandom_range(0, 15));
      mem_wdata   = $urandom;
      mem_is_load = $urandom_range(0, 1) == 1;
      mem_funct3  = 3'($urandom_range(0, 7));
      mem_addr_lo = 2'($urandom_range(0, 3));
      mem_rdata   = $urandom;
      div_valid   = ($urandom_range(0, 3) == 0);
      div_waddr   = 5'($urandom_range(16, 31));
      div_wdata   = $urandom;
      step();
    end
    idle(30);
    check("final_mem_q_empty", mem_q.size(), 32'd0);
    check("final_div_q_empty", div_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
